// File: rtl/sme_param_engine.sv
// Byte-serial string matcher with '.', '*', '^', '$' wildcards and nocase mode.
// Define SME_MATCH_LEN_EN to add the match_len result port.
module sme_param_engine #(
  parameter int CW      = 8,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int IW      = $clog2(MAX_STR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] chardata,
  input  logic          isstring,
  input  logic          ispattern,
  input  logic          nocase,
  output logic          busy,
  output logic          valid,
  output logic          match,
  output logic [IW-1:0] match_index
`ifdef SME_MATCH_LEN_EN
  ,
  output logic [IW-1:0] match_len
`endif
);

  localparam int SW  = $clog2(MAX_STR + 1);
  localparam int PW  = $clog2(MAX_PAT + 1);
  localparam int PIW = $clog2(MAX_PAT);

  localparam logic [CW-1:0] C_DOT   = CW'(8'h2E);
  localparam logic [CW-1:0] C_CARET = CW'(8'h5E);
  localparam logic [CW-1:0] C_DOLL  = CW'(8'h24);
  localparam logic [CW-1:0] C_STAR  = CW'(8'h2A);
  localparam logic [CW-1:0] C_SPACE = CW'(8'h20);

  typedef enum logic [2:0] {
    IDLE, LOAD_PAT, SEARCH, BACKTRACK, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] str_buf [MAX_STR];
  logic [CW-1:0] pat_buf [MAX_PAT];
  logic [SW-1:0] str_len, st, s, s_star;
  logic [PW-1:0] pat_len, p, p_star;
  logic          prev_str, nc, has_star;

  logic [CW-1:0] cur_s, prev_c, cur_p;
  logic s_in, pat_done, last_start, bt_over;
  logic elem_ok, adv_s, is_star;
  logic do_hit, do_miss, do_next, do_star;
  logic do_adv, do_bt, go_bt;

  function automatic logic [CW-1:0] fold(
    input logic [CW-1:0] c,
    input logic          en
  );
    fold = c;
    if (en && c >= CW'(8'h41) && c <= CW'(8'h5A))
      fold = c | CW'(8'h20);
  endfunction

  // Element evaluation at the current (s, p) pointers.
  always_comb begin
    cur_s      = str_buf[IW'(s)];
    prev_c     = str_buf[IW'(s - SW'(1))];
    cur_p      = pat_buf[PIW'(p)];
    s_in       = s < str_len;
    pat_done   = p == pat_len;
    last_start = ({1'b0, st} + (SW+1)'(1)) >= {1'b0, str_len};
    bt_over    = ({1'b0, s_star} + (SW+1)'(1)) > {1'b0, str_len};
    is_star    = cur_p == C_STAR;
    elem_ok    = 1'b0;
    adv_s      = 1'b0;
    unique case (1'b1)
      is_star:          elem_ok = 1'b1;
      cur_p == C_CARET: elem_ok = (s == '0) || (prev_c == C_SPACE);
      cur_p == C_DOLL:
        elem_ok = (s == str_len) || (s_in && cur_s == C_SPACE);
      cur_p == C_DOT: begin
        elem_ok = s_in;
        adv_s   = 1'b1;
      end
      default: begin
        elem_ok = s_in && (fold(cur_s, nc) == fold(cur_p, nc));
        adv_s   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    valid   = 1'b0;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_next = 1'b0;
    do_star = 1'b0;
    do_adv  = 1'b0;
    do_bt   = 1'b0;
    go_bt   = 1'b0;
    unique case (state)
      IDLE:
        if (!isstring && ispattern) state_n = LOAD_PAT;
      LOAD_PAT: begin
        busy = 1'b1;
        if (!ispattern) state_n = SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (pat_done)            do_hit  = 1'b1;
        else if (str_len == '0)  do_miss = 1'b1;
        else if (is_star)        do_star = 1'b1;
        else if (elem_ok)        do_adv  = 1'b1;
        else if (has_star)       go_bt   = 1'b1;
        else if (last_start)     do_miss = 1'b1;
        else                     do_next = 1'b1;
        if (do_hit || do_miss) state_n = DONE;
        else if (go_bt)        state_n = BACKTRACK;
      end
      BACKTRACK: begin
        busy = 1'b1;
        if (!bt_over)        do_bt   = 1'b1;
        else if (last_start) do_miss = 1'b1;
        else                 do_next = 1'b1;
        state_n = do_miss ? DONE : SEARCH;
      end
      DONE: begin
        valid   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      str_len     <= '0;
      pat_len     <= '0;
      prev_str    <= 1'b0;
      nc          <= 1'b0;
      st          <= '0;
      s           <= '0;
      s_star      <= '0;
      p           <= '0;
      p_star      <= '0;
      has_star    <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
`ifdef SME_MATCH_LEN_EN
      match_len   <= '0;
`endif
    end else begin
      prev_str <= isstring && (state == IDLE);
      if (state == IDLE && isstring) begin
        if (!prev_str) begin
          str_buf[0] <= chardata;
          str_len    <= SW'(1);
        end else if (str_len < SW'(MAX_STR)) begin
          str_buf[IW'(str_len)] <= chardata;
          str_len <= str_len + SW'(1);
        end
      end
      if (state == IDLE && !isstring && ispattern) begin
        pat_buf[0] <= chardata;
        pat_len    <= PW'(1);
        nc         <= nocase;
      end
      if (state == LOAD_PAT && ispattern && pat_len < PW'(MAX_PAT)) begin
        pat_buf[PIW'(pat_len)] <= chardata;
        pat_len <= pat_len + PW'(1);
      end
      if (state == LOAD_PAT && !ispattern) begin
        st       <= '0;
        s        <= '0;
        p        <= '0;
        has_star <= 1'b0;
      end
      if (do_star) begin
        p_star   <= p + PW'(1);
        s_star   <= s;
        has_star <= 1'b1;
        p        <= p + PW'(1);
      end
      if (do_adv) begin
        p <= p + PW'(1);
        if (adv_s) s <= s + SW'(1);
      end
      // Grow the '*' run by one char and replay the tail.
      if (do_bt) begin
        s_star <= s_star + SW'(1);
        s      <= s_star + SW'(1);
        p      <= p_star;
      end
      if (do_next) begin
        st       <= st + SW'(1);
        s        <= st + SW'(1);
        p        <= '0;
        has_star <= 1'b0;
      end
      if (do_hit) begin
        match       <= 1'b1;
        match_index <= IW'(st);
`ifdef SME_MATCH_LEN_EN
        match_len   <= IW'(s - st);
`endif
      end
      if (do_miss) begin
        match       <= 1'b0;
        match_index <= '0;
`ifdef SME_MATCH_LEN_EN
        match_len   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sme_param_engine.sv
// Directed bench for sme_param_engine with a reference matcher model.
// The model works on whole strings: split at '*', try each start and run length.
module tb_sme_param_engine;

  localparam int CW = 8;
  localparam int MS = 32;
  localparam int MP = 8;
  localparam int IW = 5;

  typedef logic [7:0] ch_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] chardata = '0;
  logic          isstring = 1'b0;
  logic          ispattern = 1'b0;
  logic          nocase = 1'b0;
  logic          busy, valid, match;
  logic [IW-1:0] match_index;
`ifdef SME_MATCH_LEN_EN
  logic [IW-1:0] match_len;
`endif

  always #5 clk = ~clk;

  sme_param_engine #(
    .CW(CW), .MAX_STR(MS), .MAX_PAT(MP), .IW(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chardata(chardata),
    .isstring(isstring),
    .ispattern(ispattern),
    .nocase(nocase),
    .busy(busy),
    .valid(valid),
    .match(match),
    .match_index(match_index)
`ifdef SME_MATCH_LEN_EN
    ,
    .match_len(match_len)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  ch_t   m_str [MS];
  int    m_slen = 0;
  ch_t   m_pat [MP];
  int    m_plen = 0;
  bit    m_nc = 1'b0;

  bit    pending = 1'b0;
  bit    got = 1'b0;
  int    n_valid = 0;
  bit    e_m;
  int    e_idx, e_len;
  string cur_tag = "";
  ch_t   tx[$];

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic ch_t fold(ch_t c);
    if (m_nc && c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
    return c;
  endfunction

  function automatic bit elem(int pi, int si, output int nsi);
    ch_t e;
    e = m_pat[pi];
    nsi = si;
    case (e)
      8'h5E: return (si == 0) ? 1'b1 : (m_str[si-1] == 8'h20);
      8'h24: begin
        if (si == m_slen) return 1'b1;
        return (si < m_slen) && (m_str[si] == 8'h20);
      end
      8'h2E: begin
        nsi = si + 1;
        return si < m_slen;
      end
      default: begin
        nsi = si + 1;
        if (si >= m_slen) return 1'b0;
        return fold(m_str[si]) == fold(e);
      end
    endcase
  endfunction

  function automatic bit seg(int a, int b, int si, output int e);
    int pos, np;
    pos = si;
    for (int i = a; i < b; i++) begin
      if (!elem(i, pos, np)) begin
        e = pos;
        return 1'b0;
      end
      pos = np;
    end
    e = pos;
    return 1'b1;
  endfunction

  task automatic model(output bit m, output int idx, output int len);
    int star, e1, e2;
    star = -1;
    m = 1'b0; idx = 0; len = 0;
    for (int i = 0; i < m_plen; i++)
      if (m_pat[i] == 8'h2A && star < 0) star = i;
    for (int st = 0; st < m_slen; st++) begin
      if (star < 0) begin
        if (seg(0, m_plen, st, e1)) begin
          m = 1'b1; idx = st; len = e1 - st;
          return;
        end
      end else if (seg(0, star, st, e1)) begin
        for (int k = e1; k <= m_slen; k++)
          if (seg(star + 1, m_plen, k, e2)) begin
            m = 1'b1; idx = st; len = e2 - st;
            return;
          end
      end
    end
  endtask

  // Single compare process: every valid strobe is checked against the model.
  always @(negedge clk) begin
    if (reset && valid) begin
      n_valid++;
      if (!pending) begin
        chk("unexpected_valid", int'(pending), 1);
      end else begin
        chk({cur_tag, ".match"}, int'(match), int'(e_m));
        chk({cur_tag, ".index"}, int'(match_index), e_idx);
`ifdef SME_MATCH_LEN_EN
        chk({cur_tag, ".len"}, int'(match_len), e_len);
`endif
        pending = 1'b0;
        got = 1'b1;
      end
    end
  end

  task automatic set_tx(string t);
    tx.delete();
    for (int i = 0; i < t.len(); i++) tx.push_back(ch_t'(t[i]));
  endtask

  task automatic send_str();
    for (int i = 0; i < tx.size(); i++) begin
      chardata = tx[i];
      isstring = 1'b1;
      if (i < MS) m_str[i] = tx[i];
      @(negedge clk);
    end
    isstring = 1'b0;
    m_slen = (tx.size() < MS) ? tx.size() : MS;
  endtask

  task automatic drive_pat(string t, bit nc);
    set_tx(t);
    nocase = nc;
    m_nc = nc;
    for (int i = 0; i < tx.size(); i++) begin
      chardata = tx[i];
      ispattern = 1'b1;
      if (i < MP) m_pat[i] = tx[i];
      @(negedge clk);
    end
    ispattern = 1'b0;
    m_plen = (tx.size() < MP) ? tx.size() : MP;
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (!got && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done"}, int'(got), 1);
    pending = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pat(string tag, string t, bit nc,
                          bit xm, int xi, int xl, bit poke);
    bit mm;
    int mi, ml;
    drive_pat(t, nc);
    model(mm, mi, ml);
    chk({tag, ".model_m"}, int'(mm), int'(xm));
    chk({tag, ".model_i"}, mi, xi);
    chk({tag, ".model_l"}, ml, xl);
    e_m = mm; e_idx = mi; e_len = ml;
    cur_tag = tag;
    got = 1'b0;
    pending = 1'b1;
    chk({tag, ".busy"}, int'(busy), 1);
    if (poke) begin
      chardata = 8'h5A;
      isstring = 1'b1;
      repeat (2) @(negedge clk);
      isstring = 1'b0;
    end
    wait_done(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    repeat (3) @(negedge clk);
    chk("rst.valid", int'(valid), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.match", int'(match), 0);
    chk("rst.index", int'(match_index), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle.busy", int'(busy), 0);

    set_tx("hello world");
    send_str();
    send_pat("t1", "wor", 1'b0, 1'b1, 6, 3, 1'b0);
    send_pat("t2a", "^wor", 1'b0, 1'b1, 6, 3, 1'b0);
    send_pat("t2b", "o$", 1'b0, 1'b1, 4, 1, 1'b0);
    send_pat("t2c", "h.l", 1'b0, 1'b1, 0, 3, 1'b0);
    send_pat("t3a", "l*d", 1'b0, 1'b1, 2, 9, 1'b1);
    send_pat("t3b", "xyz", 1'b0, 1'b0, 0, 0, 1'b0);
    send_pat("t3c", "hello worXXX", 1'b0, 1'b1, 0, 8, 1'b0);

    set_tx("Hello");
    send_str();
    send_pat("t4a", "hE", 1'b1, 1'b1, 0, 2, 1'b0);
    send_pat("t4b", "hE", 1'b0, 1'b0, 0, 0, 1'b0);

    tx.delete();
    for (int i = 0; i < 40; i++) tx.push_back(ch_t'(8'h30 + i));
    send_str();
    send_pat("t5a", "NO", 1'b0, 1'b1, 30, 2, 1'b0);
    send_pat("t5b", "QR", 1'b0, 1'b0, 0, 0, 1'b0);

    set_tx("0123456789ABCDEFGHIJKLMNOPQRSTUV");
    send_str();
    drive_pat("*zz", 1'b0);
    repeat (20) @(negedge clk);
    chk("t6.busy_before", int'(busy), 1);
    nv = n_valid;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6.busy_after", int'(busy), 0);
    chk("t6.valid_after", int'(valid), 0);
    repeat (40) @(negedge clk);
    chk("t6.no_valid", n_valid - nv, 0);

    set_tx("abc abc");
    send_str();
    send_pat("t6b", "c a", 1'b0, 1'b1, 2, 3, 1'b0);
    send_pat("t6c", "c$", 1'b0, 1'b1, 2, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
